// File: rtl/seq_chunk_adder_if.sv
// Request/result bundle for seq_chunk_adder: operands and mode in, handshake and result out.
interface seq_chunk_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, z, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, z, cout, ovf
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock, LSB slice first,
// with the inter-slice carry held in a register.
module seq_chunk_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    seq_chunk_adder_if.slave bus
);
    localparam int unsigned N      = WIDTH / CHUNK;
    localparam int unsigned KW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    logic [0:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] beff_q, beff_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_sl, b_sl;
    logic [CHUNK:0]   chunk_res;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        beff_d  = beff_q;
        c_d     = c_q;
        sum_d   = sum_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        z_d     = z_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        // Slice select unrolled over constant offsets so every index is static.
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = beff_q[i*CHUNK +: CHUNK];
            end
        end
        chunk_res = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, c_q};

        if (state_q == S_IDLE) begin
            if (bus.start) begin
                a_d     = bus.a;
                beff_d  = bus.sub ? ~bus.b : bus.b;
                c_d     = bus.sub | bus.cin;
                k_d     = '0;
                state_d = S_RUN;
                busy_d  = 1'b1;
            end
        end else begin
            c_d = chunk_res[CHUNK];
            for (int unsigned i = 0; i < N; i++) begin
                if (k_q == KW'(i)) begin
                    sum_d[i*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
                end
            end
            if (k_q == K_LAST) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                z_d     = sum_d;
                cout_d  = chunk_res[CHUNK];
                ovf_d   = (a_q[WIDTH-1] == beff_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            beff_q  <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            beff_q  <= beff_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            z_q     <= z_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.z    = z_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder at 32/8, 16/1 and 16/16 (WIDTH/CHUNK).
module tb_seq_chunk_adder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    seq_chunk_adder_if #(.WIDTH(32)) if32 ();
    seq_chunk_adder_if #(.WIDTH(16)) if16s ();
    seq_chunk_adder_if #(.WIDTH(16)) if16w ();

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8))  dut32  (.clk(clk), .reset(reset), .bus(if32.slave));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(1))  dut16s (.clk(clk), .reset(reset), .bus(if16s.slave));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16w (.clk(clk), .reset(reset), .bus(if16w.slave));

    // Drives one request across a single sampling edge, then scrambles the operand inputs.
    task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        @(negedge clk);
        if32.start = 1'b1; if32.a = a; if32.b = b; if32.cin = cin; if32.sub = sub;
        @(negedge clk);
        if32.start = 1'b0;
        if32.a = $urandom; if32.b = $urandom;
        if32.cin = 1'($urandom_range(0, 1)); if32.sub = 1'($urandom_range(0, 1));
    endtask

    // Counts clock edges since the start sample until done (bounded).
    task automatic wait32(input int c0, output int cyc);
        cyc = c0;
        while (if32.done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (if32.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", if32.busy); else n_pass++;
        n_total++; if (if32.done !== 1'b0) $display("FAIL reset_done: got %b want 0", if32.done); else n_pass++;
        n_total++; if (if32.z !== 32'h0) $display("FAIL reset_z: got %h want 00000000", if32.z); else n_pass++;
        n_total++; if ({if32.cout, if32.ovf} !== 2'b00) $display("FAIL reset_cout_ovf: got %b want 00", {if32.cout, if32.ovf}); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] ta [5] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h0000_0007};
        logic [31:0] tb [5] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h0000_0007, 32'h0000_0005};
        logic        tc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic        ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] ez [5] = '{32'h0000_0100, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'h0000_0002};
        logic        ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        eo [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int cyc;
        for (int i = 0; i < 5; i++) begin
            start32(ta[i], tb[i], tc[i], ts[i]);
            n_total++; if (if32.busy !== 1'b1) $display("FAIL dir_busy[%0d]: got %b want 1", i, if32.busy); else n_pass++;
            wait32(0, cyc);
            n_total++; if (cyc !== 4) $display("FAIL dir_latency[%0d]: got %0d want 4", i, cyc); else n_pass++;
            n_total++; if (if32.z !== ez[i]) $display("FAIL dir_z[%0d]: got %h want %h", i, if32.z, ez[i]); else n_pass++;
            n_total++; if (if32.cout !== ec[i]) $display("FAIL dir_cout[%0d]: got %b want %b", i, if32.cout, ec[i]); else n_pass++;
            n_total++; if (if32.ovf !== eo[i]) $display("FAIL dir_ovf[%0d]: got %b want %b", i, if32.ovf, eo[i]); else n_pass++;
            n_total++; if (if32.busy !== 1'b0) $display("FAIL dir_busy_at_done[%0d]: got %b want 0", i, if32.busy); else n_pass++;
            @(negedge clk);
            n_total++; if (if32.done !== 1'b0) $display("FAIL dir_done_width[%0d]: got %b want 0", i, if32.done); else n_pass++;
            n_total++; if (if32.z !== ez[i]) $display("FAIL dir_z_hold[%0d]: got %h want %h", i, if32.z, ez[i]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ta [4] = '{32'h1234_5678, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        logic [31:0] tb [4] = '{32'h9ABC_DEF0, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000};
        logic        tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        ts [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ez [4] = '{32'hACF1_3568, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        logic        ec [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic        eo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int cyc;
        start32(ta[0], tb[0], tc[0], ts[0]);
        for (int i = 0; i < 4; i++) begin
            wait32(0, cyc);
            n_total++; if (cyc !== 4) $display("FAIL b2b_latency[%0d]: got %0d want 4", i, cyc); else n_pass++;
            n_total++; if ({if32.cout, if32.ovf, if32.z} !== {ec[i], eo[i], ez[i]})
                $display("FAIL b2b_result[%0d]: got c=%b o=%b z=%h want c=%b o=%b z=%h",
                         i, if32.cout, if32.ovf, if32.z, ec[i], eo[i], ez[i]);
            else n_pass++;
            if (i < 3) begin
                if32.start = 1'b1; if32.a = ta[i+1]; if32.b = tb[i+1]; if32.cin = tc[i+1]; if32.sub = ts[i+1];
                @(negedge clk);
                if32.start = 1'b0;
                n_total++; if (if32.busy !== 1'b1) $display("FAIL b2b_accept[%0d]: got busy=%b want 1", i + 1, if32.busy); else n_pass++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_start_in_run;
        int cyc;
        int ndone = 0;
        start32(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        @(negedge clk);
        if32.start = 1'b1; if32.a = 32'hFFFF_FFFF; if32.b = 32'hFFFF_FFFF; if32.sub = 1'b0;
        @(negedge clk);
        if32.start = 1'b0;
        wait32(2, cyc);
        n_total++; if (cyc !== 4) $display("FAIL run_start_latency: got %0d want 4", cyc); else n_pass++;
        n_total++; if (if32.z !== 32'h3333_3333) $display("FAIL run_start_z: got %h want 33333333", if32.z); else n_pass++;
        repeat (8) begin
            @(negedge clk);
            if (if32.done === 1'b1) ndone++;
        end
        n_total++; if (ndone !== 0) $display("FAIL run_start_extra_done: got %0d want 0", ndone); else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        int ndone = 0;
        start32(32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b0);
        wait32(0, ndone);
        ndone = 0;
        start32(32'hAAAA_AAAA, 32'h1111_1111, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_total++; if (if32.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", if32.busy); else n_pass++;
        n_total++; if (if32.done !== 1'b0) $display("FAIL abort_done: got %b want 0", if32.done); else n_pass++;
        n_total++; if (if32.z !== 32'h0) $display("FAIL abort_z: got %h want 00000000", if32.z); else n_pass++;
        n_total++; if (if32.cout !== 1'b0) $display("FAIL abort_cout: got %b want 0", if32.cout); else n_pass++;
        repeat (8) begin
            @(negedge clk);
            if (if32.done === 1'b1) ndone++;
        end
        n_total++; if (ndone !== 0) $display("FAIL abort_late_done: got %0d want 0", ndone); else n_pass++;
    endtask

    // WIDTH=16, CHUNK=1: sixteen single-bit steps per operation, issued back to back.
    task automatic test_bit_serial;
        logic [15:0] ta [4] = '{16'h00FF, 16'h7FFF, 16'h0003, 16'hFFFF};
        logic [15:0] tb [4] = '{16'h0001, 16'h0001, 16'h0005, 16'h0000};
        logic        tc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic        ts [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] ez [4] = '{16'h0100, 16'h8000, 16'hFFFE, 16'h0000};
        logic        ec [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic        eo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        int cyc;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if16s.start = 1'b1; if16s.a = ta[i]; if16s.b = tb[i]; if16s.cin = tc[i]; if16s.sub = ts[i];
            @(negedge clk);
            if16s.start = 1'b0; if16s.a = 16'h5A5A; if16s.sub = ~ts[i];
            cyc = 0;
            while (if16s.done !== 1'b1 && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            n_total++; if (cyc !== 16) $display("FAIL serial_latency[%0d]: got %0d want 16", i, cyc); else n_pass++;
            n_total++; if ({if16s.cout, if16s.ovf, if16s.z} !== {ec[i], eo[i], ez[i]})
                $display("FAIL serial_result[%0d]: got c=%b o=%b z=%h want c=%b o=%b z=%h",
                         i, if16s.cout, if16s.ovf, if16s.z, ec[i], eo[i], ez[i]);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    // WIDTH=16, CHUNK=16: a single RUN cycle per operation, issued back to back.
    task automatic test_single_chunk;
        logic [15:0] ta [3] = '{16'h1234, 16'h8000, 16'hFFFF};
        logic [15:0] tb [3] = '{16'h4321, 16'h0001, 16'hFFFF};
        logic        tc [3] = '{1'b1, 1'b0, 1'b0};
        logic        ts [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] ez [3] = '{16'h5556, 16'h7FFF, 16'hFFFE};
        logic        ec [3] = '{1'b0, 1'b1, 1'b1};
        logic        eo [3] = '{1'b0, 1'b1, 1'b0};
        int cyc;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if16w.start = 1'b1; if16w.a = ta[i]; if16w.b = tb[i]; if16w.cin = tc[i]; if16w.sub = ts[i];
            @(negedge clk);
            if16w.start = 1'b0; if16w.b = 16'hA5A5;
            n_total++; if (if16w.busy !== 1'b1) $display("FAIL single_busy[%0d]: got %b want 1", i, if16w.busy); else n_pass++;
            cyc = 0;
            while (if16w.done !== 1'b1 && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            n_total++; if (cyc !== 1) $display("FAIL single_latency[%0d]: got %0d want 1", i, cyc); else n_pass++;
            n_total++; if ({if16w.cout, if16w.ovf, if16w.z} !== {ec[i], eo[i], ez[i]})
                $display("FAIL single_result[%0d]: got c=%b o=%b z=%h want c=%b o=%b z=%h",
                         i, if16w.cout, if16w.ovf, if16w.z, ec[i], eo[i], ez[i]);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        if32.start = 1'b0; if32.a = '0; if32.b = '0; if32.cin = 1'b0; if32.sub = 1'b0;
        if16s.start = 1'b0; if16s.a = '0; if16s.b = '0; if16s.cin = 1'b0; if16s.sub = 1'b0;
        if16w.start = 1'b0; if16w.a = '0; if16w.b = '0; if16w.cin = 1'b0; if16w.sub = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_in_run();
        test_reset_mid_run();
        test_bit_serial();
        test_single_chunk();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
